// File: rtl/soc_msp430_dac_mc.sv
// Multi-channel SPI-loaded DAC register block: 16-bit frames select a channel, a command and data.
// Optional build macro DAC_LDAC_EN adds the ldac_n pin (falling edge copies all input registers to vout).
module soc_msp430_dac_mc #(
  parameter int NCH       = 4,
  parameter int DW        = 12,
  parameter bit SCLK_EDGE = 1'b0
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              din,
  input  logic              sclk,
  input  logic              sync_n,
`ifdef DAC_LDAC_EN
  input  logic              ldac_n,
`endif
  output logic [NCH*DW-1:0] vout,
  output logic [NCH-1:0]    pd,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic SCLK_IDLE = ~SCLK_EDGE;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Synchroniser chains: bit0/bit1 are the 2-flop synchroniser, bit2 the edge-detect copy.
  logic [2:0]    r_sync_sr;
  logic [2:0]    r_sclk_sr;
  logic [1:0]    r_din_sr;
  logic [2:0]    r_live;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_cnt;
  logic [15:0]   r_shift;
  logic [DW-1:0] r_inreg [NCH];
  logic [DW-1:0] r_dac   [NCH];
  logic [DW-1:0] w_in_nxt[NCH];
  logic [NCH-1:0] w_sel;
  logic [NCH-1:0] r_pd;
  logic          r_frame_done;
  logic          r_frame_err;
  logic          w_sync_fall;
  logic          w_sync_rise;
  logic          w_sclk_edge;
  logic          w_shifting;
  logic          w_frame_end;
  logic          w_ldac_fall;
  logic [1:0]    w_ch;
  logic [1:0]    w_cmd;
  logic [DW-1:0] w_data;
  logic          w_ch_ok;
  logic          w_accept;
  logic          w_reject;
  logic          w_copy_all;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_sr <= 3'b111;
      r_sclk_sr <= {3{SCLK_IDLE}};
      r_din_sr  <= 2'b00;
      r_live    <= 3'b000;
    end else begin
      r_sync_sr <= {r_sync_sr[1:0], sync_n};
      r_sclk_sr <= {r_sclk_sr[1:0], sclk};
      r_din_sr  <= {r_din_sr[0], din};
      r_live    <= {r_live[1:0], 1'b1};
    end
  end

  // r_live[2] marks the edge-detect copy as holding real samples, so a sync_n
  // already low at reset release is not mistaken for a falling edge.
  assign w_sync_fall = r_live[2] &  r_sync_sr[2] & ~r_sync_sr[1];
  assign w_sync_rise = r_live[2] & ~r_sync_sr[2] &  r_sync_sr[1];
  assign w_sclk_edge = SCLK_EDGE ? (~r_sclk_sr[2] &  r_sclk_sr[1])
                                 : ( r_sclk_sr[2] & ~r_sclk_sr[1]);

`ifdef DAC_LDAC_EN
  logic [2:0] r_ldac_sr;
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) r_ldac_sr <= 3'b111;
    else          r_ldac_sr <= {r_ldac_sr[1:0], ldac_n};
  end
  assign w_ldac_fall = r_live[2] & r_ldac_sr[2] & ~r_ldac_sr[1];
`else
  assign w_ldac_fall = 1'b0;
`endif

  // Frame FSM: state register / next state / outputs.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sync_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_sync_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shifting  = (r_state == ST_SHIFT) & ~r_sync_sr[1];
    w_frame_end = (r_state == ST_SHIFT) &  w_sync_rise;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 5'd0;
      r_shift <= 16'd0;
    end else if (w_sync_fall) begin
      r_cnt   <= 5'd0;
      r_shift <= 16'd0;
    end else if (w_shifting && w_sclk_edge) begin
      r_shift <= {r_shift[14:0], r_din_sr[1]};
      if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
    end
  end

  assign w_ch     = r_shift[15:14];
  assign w_cmd    = r_shift[13:12];
  assign w_data   = r_shift[11 -: DW];
  assign w_ch_ok  = 32'(w_ch) < NCH;
  assign w_accept = w_frame_end & (r_cnt == 5'd16) & w_ch_ok;
  assign w_reject = w_frame_end & ~w_accept;

  // Input-register next values feed the copy so an LDAC in the same cycle sees this frame's write.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_sel[k]    = w_accept & (32'(w_ch) == k);
      w_in_nxt[k] = r_inreg[k];
      if (w_sel[k] && !w_cmd[1]) w_in_nxt[k] = w_data;
    end
  end

  assign w_copy_all = (w_accept & (w_cmd == 2'b10)) | w_ldac_fall;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_inreg[k] <= '0;
        r_dac[k]   <= '0;
      end
      r_pd         <= '1;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_accept;
      r_frame_err  <= w_reject;
      for (int k = 0; k < NCH; k++) begin
        r_inreg[k] <= w_in_nxt[k];
        if (w_copy_all)
          r_dac[k] <= w_in_nxt[k];
        else if (w_sel[k] && (w_cmd == 2'b01))
          r_dac[k] <= w_data;
        if (w_sel[k] && (w_cmd == 2'b01))
          r_pd[k] <= 1'b0;
        else if (w_sel[k] && (w_cmd == 2'b11))
          r_pd[k] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_vout
    assign vout[g*DW +: DW] = r_pd[g] ? '0 : r_dac[g];
  end

  assign pd         = r_pd;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_soc_msp430_dac_mc.sv
// Directed bench for soc_msp430_dac_mc: a 4ch/12-bit and a 2ch/8-bit instance share the SPI pins.
// Builds with or without DAC_LDAC_EN.
module tb_soc_msp430_dac_mc;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        reset_n;
  logic        din;
  logic        sclk;
  logic        sync_n;
`ifdef DAC_LDAC_EN
  logic        ldac_n;
`endif
  logic [47:0] a_vout;
  logic [3:0]  a_pd;
  logic        a_done;
  logic        a_err;
  logic [15:0] b_vout;
  logic [1:0]  b_pd;
  logic        b_done;
  logic        b_err;

  soc_msp430_dac_mc #(.NCH(4), .DW(12), .SCLK_EDGE(1'b0)) dut_a (
    .mclk(mclk), .reset_n(reset_n), .din(din), .sclk(sclk), .sync_n(sync_n),
`ifdef DAC_LDAC_EN
    .ldac_n(ldac_n),
`endif
    .vout(a_vout), .pd(a_pd), .frame_done(a_done), .frame_err(a_err)
  );

  soc_msp430_dac_mc #(.NCH(2), .DW(8), .SCLK_EDGE(1'b0)) dut_b (
    .mclk(mclk), .reset_n(reset_n), .din(din), .sclk(sclk), .sync_n(sync_n),
`ifdef DAC_LDAC_EN
    .ldac_n(ldac_n),
`endif
    .vout(b_vout), .pd(b_pd), .frame_done(b_done), .frame_err(b_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int a_done_n = 0, a_err_n = 0, b_done_n = 0, b_err_n = 0;
  int s_ad, s_ae, s_bd, s_be;

  // Pulse counters sampled on the falling edge, away from the DUT's active edge.
  always @(negedge mclk) begin
    if (a_done === 1'b1) a_done_n++;
    if (a_err  === 1'b1) a_err_n++;
    if (b_done === 1'b1) b_done_n++;
    if (b_err  === 1'b1) b_err_n++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_ad = a_done_n; s_ae = a_err_n; s_bd = b_done_n; s_be = b_err_n;
  endtask

  task automatic expect_all(input string tag,
                            input logic [47:0] va, input logic [3:0] pa, input int da, input int ea,
                            input logic [15:0] vb, input logic [1:0] pb, input int db, input int eb);
    chk({tag, " a_vout"}, 64'(a_vout), 64'(va));
    chk({tag, " a_pd"},   64'(a_pd),   64'(pa));
    chk({tag, " a_done"}, 64'(a_done_n - s_ad), 64'(da));
    chk({tag, " a_err"},  64'(a_err_n - s_ae),  64'(ea));
    chk({tag, " b_vout"}, 64'(b_vout), 64'(vb));
    chk({tag, " b_pd"},   64'(b_pd),   64'(pb));
    chk({tag, " b_done"}, 64'(b_done_n - s_bd), 64'(db));
    chk({tag, " b_err"},  64'(b_err_n - s_be),  64'(eb));
  endtask

  // Drive times sit 2 ns after a falling mclk edge so they never coincide with a clock edge.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    @(negedge mclk);
    #2;
    sync_n = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      din = bits[i];
      #40 sclk = 1'b0;
      #40 sclk = 1'b1;
    end
    #40;
  endtask

  task automatic end_frame();
    sync_n = 1'b1;
    repeat (8) @(negedge mclk);
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n);
    snap();
    shift_bits(bits, n);
    end_frame();
  endtask

  initial begin
    reset_n = 1'b1;
    sync_n  = 1'b1;
    sclk    = 1'b1;
    din     = 1'b0;
`ifdef DAC_LDAC_EN
    ldac_n  = 1'b1;
`endif
    #2 reset_n = 1'b0;
    #1;
    snap();
    expect_all("reset", 48'h0, 4'hF, 0, 0, 16'h0, 2'b11, 0, 0);
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    repeat (5) @(negedge mclk);

    // ch0 cmd01 with edge-by-edge latency checks after sync_n rises
    snap();
    shift_bits(32'h1ABC, 16);
    sync_n = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    chk("lat_edge2 a_done", 64'(a_done), 64'h0);
    chk("lat_edge2 a_vout", 64'(a_vout), 64'h0);
    @(negedge mclk);
    chk("lat_edge3 a_done", 64'(a_done), 64'h1);
    chk("lat_edge3 a_vout", 64'(a_vout), 64'hABC);
    chk("lat_edge3 b_vout", 64'(b_vout), 64'hAB);
    @(negedge mclk);
    chk("lat_edge4 a_done", 64'(a_done), 64'h0);
    repeat (5) @(negedge mclk);
    expect_all("f1ABC", 48'h000_000_000_ABC, 4'hE, 1, 0, 16'h00AB, 2'b10, 1, 0);

    run_frame(32'h5000, 16);
    expect_all("f5000", 48'h000_000_000_ABC, 4'hC, 1, 0, 16'h00AB, 2'b00, 1, 0);
    run_frame(32'h4123, 16);
    expect_all("f4123", 48'h000_000_000_ABC, 4'hC, 1, 0, 16'h00AB, 2'b00, 1, 0);
    run_frame(32'h2000, 16);
    expect_all("f2000", 48'h000_000_123_ABC, 4'hC, 1, 0, 16'h12AB, 2'b00, 1, 0);

    run_frame(32'h0ABC, 15);
    expect_all("short15", 48'h000_000_123_ABC, 4'hC, 0, 1, 16'h12AB, 2'b00, 0, 1);
    run_frame(32'h1ABCD, 17);
    expect_all("long17", 48'h000_000_123_ABC, 4'hC, 0, 1, 16'h12AB, 2'b00, 0, 1);

    // ch2 exists only on the 4-channel instance
    run_frame(32'h9FFF, 16);
    expect_all("f9FFF", 48'h000_FFF_123_ABC, 4'h8, 1, 0, 16'h12AB, 2'b00, 0, 1);

    run_frame(32'h3000, 16);
    expect_all("f3000", 48'h000_FFF_123_000, 4'h9, 1, 0, 16'h1200, 2'b01, 1, 0);
    run_frame(32'h1ABC, 16);
    expect_all("f1ABC_again", 48'h000_FFF_123_ABC, 4'h8, 1, 0, 16'h12AB, 2'b00, 1, 0);

    // sclk activity with sync_n high must not disturb anything
    snap();
    for (int i = 0; i < 6; i++) begin
      din = 1'($urandom_range(0, 1));
      #40 sclk = 1'b0;
      #40 sclk = 1'b1;
    end
    repeat (4) @(negedge mclk);
    expect_all("idle_sclk", 48'h000_FFF_123_ABC, 4'h8, 0, 0, 16'h12AB, 2'b00, 0, 0);

`ifdef DAC_LDAC_EN
    snap();
    shift_bits(32'h0555, 16);
    sync_n = 1'b1;
    ldac_n = 1'b0;
    repeat (8) @(negedge mclk);
    ldac_n = 1'b1;
    repeat (4) @(negedge mclk);
    expect_all("ldac_same_cycle", 48'h000_FFF_123_555, 4'h8, 1, 0, 16'h1255, 2'b00, 1, 0);
`else
    run_frame(32'h0555, 16);
    expect_all("f0555", 48'h000_FFF_123_ABC, 4'h8, 1, 0, 16'h12AB, 2'b00, 1, 0);
    run_frame(32'h2000, 16);
    expect_all("f2000_copy", 48'h000_FFF_123_555, 4'h8, 1, 0, 16'h1255, 2'b00, 1, 0);
`endif

    // reset at bit 8; sync_n stays low through release and the frame must not count
    snap();
    shift_bits(32'h001A, 8);
    reset_n = 1'b0;
    #1;
    expect_all("midreset_now", 48'h0, 4'hF, 0, 0, 16'h0, 2'b11, 0, 0);
    #19;
    @(negedge mclk);
    reset_n = 1'b1;
    shift_bits(32'h00BC, 8);
    end_frame();
    expect_all("midreset_after", 48'h0, 4'hF, 0, 0, 16'h0, 2'b11, 0, 0);

    run_frame(32'h1ABC, 16);
    expect_all("post_reset_frame", 48'h000_000_000_ABC, 4'hE, 1, 0, 16'h00AB, 2'b10, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/soc_msp430_dac_mc.md
SOC_MSP430_DAC_MC -- requirements
Module: soc_msp430_dac_mc

Interface
REQ-001 Parameter NCH, default 4, number of DAC channels (1..4) SHALL be supported.
REQ-002 Parameter DW, default 12, output resolution in bits (8..12); channel value SHALL be frame bits [11:12-DW].
REQ-003 Parameter SCLK_EDGE, default 0, SPI sampling edge: 0 = sclk falling, 1 = sclk rising.
REQ-004 mclk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 din  input  1  SPI serial data, MSB first.
REQ-007 sclk  input  1  SPI serial clock, asynchronous to mclk.
REQ-008 sync_n  input  1  SPI frame select, active low.
REQ-009 vout  output  NCH*DW  channel outputs, channel k at bits [k*DW+DW-1:k*DW].
REQ-010 pd  output  NCH  per-channel power-down flags.
REQ-011 frame_done  output  1  one-mclk pulse on each accepted frame.
REQ-012 frame_err  output  1  one-mclk pulse on each rejected frame.

Function
REQ-013 din, sclk and sync_n SHALL each pass a 2-flop mclk synchroniser; edges SHALL be detected against a third registered copy.
REQ-014 sclk high and low times SHALL be at least 3 mclk periods; shorter pulses are out of scope.
REQ-015 Synchronised sync_n falling edge SHALL clear the 5-bit bit counter and shifter.
REQ-016 While sync_n is low, each selected sclk edge SHALL shift din into a 16-bit shifter and increment the counter, saturating at 17.
REQ-017 Frame format: [15:14] channel, [13:12] command, [11:0] data.
REQ-018 On sync_n rising edge with counter == 16 and channel < NCH, the frame SHALL be accepted and frame_done pulsed.
REQ-019 On sync_n rising edge with counter != 16 or channel >= NCH, the frame SHALL be discarded, frame_err pulsed, no register changed.
REQ-020 Command 00: write input register of channel only.
REQ-021 Command 01: write input register and vout of channel; clear pd of channel.
REQ-022 Command 10: copy all input registers to vout (data ignored).
REQ-023 Command 11: set pd of channel; vout of that channel SHALL read 0 while pd is set; input register retained.
REQ-024 Latency: vout/pd/frame_done SHALL change on the 3rd mclk rising edge counting the first edge sampling sync_n high as the 1st.
REQ-025 A sync_n low seen at reset release without a preceding falling edge SHALL NOT start a frame.
REQ-026 sclk edges while sync_n high SHALL be ignored.

Reset
REQ-027 reset_n low SHALL immediately force vout=0, pd=all ones, input registers=0, counter=0, shifter=0, frame_done=0, frame_err=0, synchronisers to idle (sync_n=1, sclk=SCLK_EDGE ? 0 : 1).
REQ-028 reset_n asserted mid-frame SHALL abort the frame with no output pulse.

Configuration
REQ-029 With DAC_LDAC_EN defined, input port ldac_n (1 bit, active low) SHALL exist, be synchronised as in REQ-013, and its falling edge SHALL copy all input registers to vout as command 10.
REQ-030 If ldac_n falling edge and an accepted frame take effect in the same mclk cycle, the copy SHALL use the input register values written by that frame.
REQ-031 Without DAC_LDAC_EN, ldac_n SHALL be absent and vout SHALL update only via commands 01 and 10.

Verification
REQ-032 Reset, then frame 0x1ABC (ch0, cmd01) -> vout[11:0]=0xABC, pd[0]=0, frame_done one pulse.
REQ-033 Frame 0x4123 (ch1, cmd00) -> vout ch1 unchanged; then frame 0x2000 -> vout ch1=0x123.
REQ-034 15-bit frame and 17-bit frame -> frame_err one pulse each, vout/pd unchanged.
REQ-035 NCH=2, frame 0x9FFF (ch2) -> frame_err, no change; DW=8, frame 0x1ABC -> ch0=0xAB.
REQ-036 Frame 0x3000 after ch0 loaded 0xABC -> vout ch0=0, pd[0]=1; then 0x1ABC -> 0xABC, pd[0]=0.
REQ-037 DAC_LDAC_EN: ldac_n low in same cycle as 0x0555 acceptance -> vout ch0=0x555; reset_n pulsed at bit 8 -> no pulse, all outputs at reset values.
